// File: rtl/vt_math_pkg.sv
// Shared width helpers and stage record for the vector-magnitude datapath.
package vt_math_pkg;

    localparam int VT_W = 16;

    function automatic int sq_w(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int mag_w(input int w);
        return w + 1;
    endfunction

    function automatic int lat_w(input int w);
        return w + 3;
    endfunction

    localparam int VT_LAT = lat_w(VT_W);

    // Record layout at the default width; the modules carry the same fields at their own W.
    typedef struct packed {
        logic                 valid;
        logic [VT_W:0]        root;
        logic [VT_W+1:0]      rem;
        logic [2*VT_W+1:0]    rad;
        logic [2*VT_W+1:0]    sumsq;
        logic [7:0]           tag;
    } vt_stage_t;

endpackage

// File: rtl/vec_mag_pipe_sqrt_stage.sv
// One registered restoring square-root iteration: consumes one radicand bit pair,
// produces one root bit.
module sqrt_stage
    import vt_math_pkg::*;
#(
    parameter int W     = 16,
    parameter int STAGE = 0,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid_i,
    input  logic [W:0]           root_i,
    input  logic [W+1:0]         rem_i,
    input  logic [sq_w(W)-1:0]   rad_i,
    input  logic [sq_w(W)-1:0]   sumsq_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 valid_o,
    output logic [W:0]           root_o,
    output logic [W+1:0]         rem_o,
    output logic [sq_w(W)-1:0]   rad_o,
    output logic [sq_w(W)-1:0]   sumsq_o,
    output logic [TAG_W-1:0]     tag_o
);
    localparam int SW = sq_w(W);
    localparam int PB = 2 * (W - STAGE);
    localparam logic [SW-1:0] PMASK = SW'(3) << PB;

    logic [W+3:0] rem_sh;
    logic [W+3:0] trial;
    logic [W+3:0] diff;
    logic         take;
    logic [W:0]   root_d;
    logic [W+1:0] rem_d;

    assign rem_sh = {rem_i, rad_i[PB +: 2]};
    assign trial  = {1'b0, root_i, 2'b01};
    assign diff   = rem_sh - trial;
    assign take   = (rem_sh >= trial);
    assign root_d = (root_i << 1) | {{W{1'b0}}, take};
    // The remainder never exceeds twice the root, so it always fits in W+2 bits.
    assign rem_d  = (W+2)'(take ? diff : rem_sh);

    logic                valid_q;
    logic [W:0]          root_q;
    logic [W+1:0]        rem_q;
    logic [SW-1:0]       rad_q;
    logic [SW-1:0]       sumsq_q;
    logic [TAG_W-1:0]    tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
            rad_q   <= '0;
            sumsq_q <= '0;
            tag_q   <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            root_q  <= root_d;
            rem_q   <= rem_d;
            rad_q   <= rad_i & ~PMASK;
            sumsq_q <= sumsq_i;
            tag_q   <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign root_o  = root_q;
    assign rem_o   = rem_q;
    assign rad_o   = rad_q;
    assign sumsq_o = sumsq_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/vec_mag_pipe.sv
// Fully pipelined floor(sqrt(x^2+y^2+z^2)) with exact squared norm, tag sideband
// and a global-stall handshake.
module vec_mag_pipe
    import vt_math_pkg::*;
#(
    parameter int W      = 16,
    parameter int SIGNED = 1,
    parameter int TAG_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          x,
    input  logic [W-1:0]          y,
    input  logic [W-1:0]          z,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [mag_w(W)-1:0]   mag,
    output logic [sq_w(W)-1:0]    sumsq,
    output logic                  exact,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int SW = sq_w(W);
    localparam int NS = W + 1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;

    // |v| still fits W unsigned bits, including the most negative value.
    function automatic logic [W-1:0] abs_of(input logic [W-1:0] v);
        return (SIGNED != 0 && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    logic [2*W-1:0] ax, ay, az;
    assign ax = {{W{1'b0}}, abs_of(x)};
    assign ay = {{W{1'b0}}, abs_of(y)};
    assign az = {{W{1'b0}}, abs_of(z)};

    logic              v0_q;
    logic [2*W-1:0]    sqx_q, sqy_q, sqz_q;
    logic [TAG_W-1:0]  tag0_q;
    logic              v1_q;
    logic [SW-1:0]     sum1_q;
    logic [TAG_W-1:0]  tag1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q   <= 1'b0;
            sqx_q  <= '0;
            sqy_q  <= '0;
            sqz_q  <= '0;
            tag0_q <= '0;
            v1_q   <= 1'b0;
            sum1_q <= '0;
            tag1_q <= '0;
        end else if (en) begin
            v0_q   <= in_valid && in_ready;
            sqx_q  <= ax * ax;
            sqy_q  <= ay * ay;
            sqz_q  <= az * az;
            tag0_q <= in_tag;
            v1_q   <= v0_q;
            sum1_q <= {2'b00, sqx_q} + {2'b00, sqy_q} + {2'b00, sqz_q};
            tag1_q <= tag0_q;
        end
    end

    logic              vld_w  [0:NS];
    logic [W:0]        root_w [0:NS];
    logic [W+1:0]      rem_w  [0:NS];
    logic [SW-1:0]     rad_w  [0:NS];
    logic [SW-1:0]     ssq_w  [0:NS];
    logic [TAG_W-1:0]  tag_w  [0:NS];

    assign vld_w[0]  = v1_q;
    assign root_w[0] = '0;
    assign rem_w[0]  = '0;
    assign rad_w[0]  = sum1_q;
    assign ssq_w[0]  = sum1_q;
    assign tag_w[0]  = tag1_q;

    for (genvar gi = 0; gi < NS; gi++) begin : g_sqrt
        sqrt_stage #(
            .W     (W),
            .STAGE (gi),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (vld_w[gi]),
            .root_i  (root_w[gi]),
            .rem_i   (rem_w[gi]),
            .rad_i   (rad_w[gi]),
            .sumsq_i (ssq_w[gi]),
            .tag_i   (tag_w[gi]),
            .valid_o (vld_w[gi+1]),
            .root_o  (root_w[gi+1]),
            .rem_o   (rem_w[gi+1]),
            .rad_o   (rad_w[gi+1]),
            .sumsq_o (ssq_w[gi+1]),
            .tag_o   (tag_w[gi+1])
        );
    end

    assign out_valid = vld_w[NS];
    assign mag       = root_w[NS];
    assign sumsq     = ssq_w[NS];
    assign exact     = vld_w[NS] && (rem_w[NS] == '0);
    assign out_tag   = tag_w[NS];

endmodule

// File: doc/vec_mag_pipe.md
Name: vec_mag_pipe

Overview:
- Parametrised, fully pipelined vector-magnitude unit for the ray tracer datapath.
- Computes floor(sqrt(x²+y²+z²)) on signed or unsigned components of width W, plus the exact squared norm.
- Uses an in-house restoring square root, so no vendor core is needed.
- Carries a tag (e.g. ray/pixel id) alongside the data.
- Has valid/ready handshakes on both sides and a global-stall backpressure scheme.

Parameters:
- W, 16: component width in bits.
- SIGNED, 1: 1 = components are two's complement; 0 = unsigned.
- TAG_W, 8: width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  unit accepts the sample this cycle
- x  in  W  component x
- y  in  W  component y
- z  in  W  component z
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- mag  out  W+1  floor(sqrt(sumsq))
- sumsq  out  2W+2  x²+y²+z², exact
- exact  out  1  1 when sumsq is a perfect square (final remainder == 0)
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset is asynchronous, active-high. While rst is high, all stage valid bits are 0. out_valid, mag, sumsq, exact and out_tag are 0. in_ready is 0 while rst is asserted.
- A reset asserted mid-operation discards all in-flight samples. The first accept after reset is on the first clk edge with rst low, in_valid=1 and in_ready=1.
- Pipeline latency L = W+3 cycles from accept to out_valid with no stall (19 for W=16):
  - Stage 0: register the three squares, each 2W bits unsigned. When SIGNED, square the sign-extended value, so (-2^(W-1))² = 2^(2W-2).
  - Stage 1: register sumsq as 2W+2 bits, with no truncation or overflow.
  - Stages 2..W+2: restoring square root, one result bit per stage, MSB first. Each stage carries the partial root, the remainder, the remaining radicand, sumsq and the tag.
- The last stage drives the outputs.
- Advance enable: en = !out_valid || out_ready. in_ready = en and not in reset.
- When en=0 every stage holds, including out_valid and all output fields. Samples are never dropped or duplicated.
- Throughput is one sample per cycle while out_ready stays high. Bubbles (in_valid=0) propagate as invalid stages.
- Simultaneous accept and retire in the same cycle is legal and keeps full throughput.
- out_valid may not fall without a handshake (out_ready=1 while out_valid=1).
- The data fields are don't-care when out_valid=0, but stage data registers are enabled only by en. This keeps power low and makes the bench deterministic.
- mag is always ≤ 2^W·√3 < 2^(W+1), so it fits in W+1 bits.

Decomposition:
- Shared package vt_math_pkg:
  - function sq_w(W) = 2W+2
  - function mag_w(W) = W+1
  - localparam-style constant for latency, W+3
  - typedef of the stage record: root, remainder, radicand, sumsq, tag, valid
- One sub-module, sqrt_stage: one restoring iteration, parametrised by stage index and W, registered, with an enable input. It is instantiated W+1 times in a generate loop.
- Squaring, the sum and the handshake logic stay in the top module.

Test Plan:
- W=16, SIGNED=1, x=3, y=4, z=0, tag=0x5A, out_ready=1 -> after exactly 19 cycles: mag=5, sumsq=25, exact=1, out_tag=0x5A.
- x=y=z=-32768 -> sumsq=3221225472, mag=56755, exact=0.
- Corner inputs:
  - x=y=z=1 -> mag=1, sumsq=3, exact=0.
  - x=y=z=0 -> mag=0, sumsq=0, exact=1.
  - SIGNED=0, x=y=z=65535 -> sumsq=12884508675, mag=113509.
- Streaming: 100 random back-to-back samples with out_ready=1 -> one result per cycle, in order, each matching the reference model for floor sqrt, with tags intact.
- Backpressure: fill the pipeline, drop out_ready for 5 cycles, then random toggling -> in_ready low while stalled, outputs stable while stalled, no loss or duplication; count and order of results equal the inputs.
- Reset: assert rst with 10 samples in flight -> outputs go to 0 at once; after release, only post-reset samples emerge, with latency 19.
